// File: rtl/cpu_register_file_pkg.sv
// Control-word field encodings shared by the microcode sequencer and the datapath register file.
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        SRC_Y     = 4'd0,
        SRC_X     = 4'd1,
        SRC_SP    = 4'd2,
        SRC_ALU   = 4'd3,
        SRC_A     = 4'd4,
        SRC_PCL   = 4'd5,
        SRC_PCH   = 4'd6,
        SRC_IDL   = 4'd7,
        SRC_DBUFF = 4'd8,
        SRC_PSR   = 4'd9,
        SRC_BZ    = 4'd10
    } bus_code_e;

    localparam int LSE_ALU_COMPUTE      = 15;
    localparam int LSE_LOAD_IR          = 14;
    localparam int LSE_LOAD_PSR         = 13;
    localparam int LSE_LOAD_Y           = 12;
    localparam int LSE_LOAD_X           = 11;
    localparam int LSE_LOAD_SP          = 10;
    localparam int LSE_LOAD_ALU         = 9;
    localparam int LSE_LOAD_A           = 8;
    localparam int LSE_LOAD_PCL         = 7;
    localparam int LSE_LOAD_PCH         = 6;
    localparam int LSE_LOAD_DATA_LATCH  = 5;
    localparam int LSE_LOAD_BUS_BUFFER  = 4;
    localparam int LSE_UPDATE_STATUS    = 3;
    localparam int LSE_MOV_ALU_TO_ACC   = 2;
    localparam int LSE_MOV_ACC_TO_ALU   = 1;
    localparam int LSE_MOV_LOW_TO_ALU   = 0;

    localparam int IDC_INC_PC    = 9;
    localparam int IDC_INC_A     = 8;
    localparam int IDC_DEC_A     = 7;
    localparam int IDC_INC_X     = 6;
    localparam int IDC_DEC_X     = 5;
    localparam int IDC_INC_Y     = 4;
    localparam int IDC_DEC_Y     = 3;
    localparam int IDC_INC_SP    = 2;
    localparam int IDC_DEC_SP    = 1;
    localparam int IDC_CLEAR_IDL = 0;

    localparam logic [7:0] PSR_N = 8'h80;
    localparam logic [7:0] PSR_U = 8'h20;
    localparam logic [7:0] PSR_B = 8'h10;
    localparam logic [7:0] PSR_I = 8'h04;
    localparam logic [7:0] PSR_Z = 8'h02;

    localparam logic [7:0] RESET_SP_C  = 8'hFF;
    localparam logic [7:0] RESET_PSR_C = PSR_I | PSR_U | PSR_B;
    localparam logic [7:0] RESET_IR_C  = 8'hEA;

    // True when the strobe that writes the given destination code is asserted.
    function automatic logic write_strobe_hit(input logic [3:0] code, input logic [15:0] lse);
        logic hit;
        case (code)
            4'd0:    hit = lse[LSE_LOAD_Y];
            4'd1:    hit = lse[LSE_LOAD_X];
            4'd2:    hit = lse[LSE_LOAD_SP];
            4'd3:    hit = lse[LSE_LOAD_ALU];
            4'd4:    hit = lse[LSE_LOAD_A];
            4'd5:    hit = lse[LSE_LOAD_PCL];
            4'd6:    hit = lse[LSE_LOAD_PCH];
            4'd7:    hit = lse[LSE_LOAD_DATA_LATCH];
            4'd8:    hit = lse[LSE_LOAD_BUS_BUFFER];
            4'd9:    hit = lse[LSE_LOAD_PSR];
            default: hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/cpu_register_file_if.sv
// Control word in, register contents out; ctrl_err exists only when CTRL_CHECK_EN is defined.
interface cpu_register_file_if;

    logic [7:0]  data_bus_set;
    logic [15:0] load_store_execute;
    logic [9:0]  inc_dec_clr;
    logic [7:0]  status_flags;
    logic [7:0]  data_in;
    logic [7:0]  alu_result;
    logic [7:0]  int_bus;
    logic [7:0]  reg_a;
    logic [7:0]  reg_x;
    logic [7:0]  reg_y;
    logic [7:0]  reg_sp;
    logic [7:0]  reg_idl;
    logic [7:0]  reg_dbuff;
    logic [7:0]  reg_psr;
    logic [7:0]  reg_ir;
    logic [15:0] pc;
`ifdef CTRL_CHECK_EN
    logic        ctrl_err;
`endif

    modport master (
        output data_bus_set, load_store_execute, inc_dec_clr, status_flags, data_in, alu_result,
        input  int_bus, reg_a, reg_x, reg_y, reg_sp, reg_idl, reg_dbuff, reg_psr, reg_ir, pc
`ifdef CTRL_CHECK_EN
        , input ctrl_err
`endif
    );

    modport slave (
        input  data_bus_set, load_store_execute, inc_dec_clr, status_flags, data_in, alu_result,
        output int_bus, reg_a, reg_x, reg_y, reg_sp, reg_idl, reg_dbuff, reg_psr, reg_ir, pc
`ifdef CTRL_CHECK_EN
        , output ctrl_err
`endif
    );

endinterface

// File: rtl/cpu_register_file_reg8.sv
// 8-bit register: load > alternate load > inc/dec; simultaneous inc and dec hold the value.
module cpu_reg8 #(
    parameter logic [7:0] RESET_VAL = 8'h00
) (
    input  logic       fclk,
    input  logic       resb,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       alt_load,
    input  logic [7:0] alt_val,
    input  logic       inc,
    input  logic       dec,
    output logic [7:0] q
);

    logic [7:0] q_r;
    logic [7:0] next_s;

    // Next value by priority
    always_comb begin
        next_s = q_r;
        if (load) begin
            next_s = load_val;
        end else if (alt_load) begin
            next_s = alt_val;
        end else if (inc && !dec) begin
            next_s = q_r + 8'd1;
        end else if (dec && !inc) begin
            next_s = q_r - 8'd1;
        end else begin
            next_s = q_r;
        end
    end

    // State register with synchronous reset
    always_ff @(posedge fclk) begin
        if (!resb) begin
            q_r <= RESET_VAL;
        end else begin
            q_r <= next_s;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/cpu_register_file.sv
// 65C02 datapath register file and internal bus; CTRL_CHECK_EN adds a sticky ctrl_err flag.
module cpu_register_file
    import cpu_ctrl_pkg::*;
#(
    parameter logic [7:0] RESET_SP  = RESET_SP_C,
    parameter logic [7:0] RESET_PSR = RESET_PSR_C,
    parameter logic [7:0] RESET_IR  = RESET_IR_C
) (
    input logic              fclk,
    input logic              resb,
    cpu_register_file_if.slave bus
);

    logic [15:0] lse_s;
    logic [9:0]  idc_s;
    bus_code_e   rd_src_s;
    logic [7:0]  int_bus_s;
    logic [7:0]  a_s, x_s, y_s, sp_s;
    logic [7:0]  idl_r, dbuff_r, psr_r, ir_r, pcl_r, pch_r;
    logic [7:0]  idl_next_s, dbuff_next_s, psr_next_s, ir_next_s, pcl_next_s, pch_next_s;
    logic [15:0] pc_inc_s;

    assign lse_s    = bus.load_store_execute;
    assign idc_s    = bus.inc_dec_clr;
    assign rd_src_s = bus_code_e'(bus.data_bus_set[7:4]);
    assign pc_inc_s = {pch_r, pcl_r} + 16'd1;

    // Internal bus source mux; DBUFF reads forward data_in when it is being loaded this cycle
    always_comb begin
        int_bus_s = 8'h00;
        case (rd_src_s)
            SRC_Y:     int_bus_s = y_s;
            SRC_X:     int_bus_s = x_s;
            SRC_SP:    int_bus_s = sp_s;
            SRC_ALU:   int_bus_s = bus.alu_result;
            SRC_A:     int_bus_s = a_s;
            SRC_PCL:   int_bus_s = pcl_r;
            SRC_PCH:   int_bus_s = pch_r;
            SRC_IDL:   int_bus_s = idl_r;
            SRC_DBUFF: int_bus_s = lse_s[LSE_LOAD_BUS_BUFFER] ? bus.data_in : dbuff_r;
            SRC_PSR:   int_bus_s = psr_r;
            SRC_BZ:    int_bus_s = 8'h00;
            default:   int_bus_s = 8'h00;
        endcase
    end

    cpu_reg8 #(.RESET_VAL(8'h00)) u_reg_a (
        .fclk(fclk), .resb(resb),
        .load(lse_s[LSE_LOAD_A]), .load_val(int_bus_s),
        .alt_load(lse_s[LSE_MOV_ALU_TO_ACC]), .alt_val(bus.alu_result),
        .inc(idc_s[IDC_INC_A]), .dec(idc_s[IDC_DEC_A]), .q(a_s)
    );

    cpu_reg8 #(.RESET_VAL(8'h00)) u_reg_x (
        .fclk(fclk), .resb(resb),
        .load(lse_s[LSE_LOAD_X]), .load_val(int_bus_s),
        .alt_load(1'b0), .alt_val(8'h00),
        .inc(idc_s[IDC_INC_X]), .dec(idc_s[IDC_DEC_X]), .q(x_s)
    );

    cpu_reg8 #(.RESET_VAL(8'h00)) u_reg_y (
        .fclk(fclk), .resb(resb),
        .load(lse_s[LSE_LOAD_Y]), .load_val(int_bus_s),
        .alt_load(1'b0), .alt_val(8'h00),
        .inc(idc_s[IDC_INC_Y]), .dec(idc_s[IDC_DEC_Y]), .q(y_s)
    );

    cpu_reg8 #(.RESET_VAL(RESET_SP)) u_reg_sp (
        .fclk(fclk), .resb(resb),
        .load(lse_s[LSE_LOAD_SP]), .load_val(int_bus_s),
        .alt_load(1'b0), .alt_val(8'h00),
        .inc(idc_s[IDC_INC_SP]), .dec(idc_s[IDC_DEC_SP]), .q(sp_s)
    );

    // Next values for the byte registers outside cpu_reg8
    always_comb begin
        idl_next_s   = idl_r;
        dbuff_next_s = dbuff_r;
        ir_next_s    = ir_r;
        pcl_next_s   = pcl_r;
        pch_next_s   = pch_r;
        psr_next_s   = psr_r;

        if (lse_s[LSE_LOAD_DATA_LATCH]) begin
            idl_next_s = bus.data_in;
        end else if (idc_s[IDC_CLEAR_IDL]) begin
            idl_next_s = 8'h00;
        end else begin
            idl_next_s = idl_r;
        end

        if (lse_s[LSE_LOAD_BUS_BUFFER]) begin
            dbuff_next_s = bus.data_in;
        end else begin
            dbuff_next_s = dbuff_r;
        end

        if (lse_s[LSE_LOAD_IR]) begin
            ir_next_s = int_bus_s;
        end else begin
            ir_next_s = ir_r;
        end

        // A loaded PC byte takes the bus; the other byte still follows the 16-bit increment
        if (lse_s[LSE_LOAD_PCL]) begin
            pcl_next_s = int_bus_s;
        end else if (idc_s[IDC_INC_PC]) begin
            pcl_next_s = pc_inc_s[7:0];
        end else begin
            pcl_next_s = pcl_r;
        end

        if (lse_s[LSE_LOAD_PCH]) begin
            pch_next_s = int_bus_s;
        end else if (idc_s[IDC_INC_PC]) begin
            pch_next_s = pc_inc_s[15:8];
        end else begin
            pch_next_s = pch_r;
        end

        if (lse_s[LSE_LOAD_PSR]) begin
            psr_next_s = int_bus_s | PSR_U;
        end else if (lse_s[LSE_UPDATE_STATUS]) begin
            psr_next_s = (psr_r & ~(PSR_N | PSR_Z)) | (int_bus_s & PSR_N)
                       | ((int_bus_s == 8'h00) ? PSR_Z : 8'h00) | bus.status_flags | PSR_U;
        end else begin
            psr_next_s = psr_r | bus.status_flags | PSR_U;
        end
    end

    // Byte register state with synchronous reset overriding the whole control word
    always_ff @(posedge fclk) begin
        if (!resb) begin
            idl_r   <= 8'h00;
            dbuff_r <= 8'h00;
            psr_r   <= RESET_PSR | PSR_U;
            ir_r    <= RESET_IR;
            pcl_r   <= 8'h00;
            pch_r   <= 8'h00;
        end else begin
            idl_r   <= idl_next_s;
            dbuff_r <= dbuff_next_s;
            psr_r   <= psr_next_s;
            ir_r    <= ir_next_s;
            pcl_r   <= pcl_next_s;
            pch_r   <= pch_next_s;
        end
    end

    assign bus.int_bus   = int_bus_s;
    assign bus.reg_a     = a_s;
    assign bus.reg_x     = x_s;
    assign bus.reg_y     = y_s;
    assign bus.reg_sp    = sp_s;
    assign bus.reg_idl   = idl_r;
    assign bus.reg_dbuff = dbuff_r;
    assign bus.reg_psr   = psr_r;
    assign bus.reg_ir    = ir_r;
    assign bus.pc        = {pch_r, pcl_r};

    logic unused_strobes_s;
    assign unused_strobes_s = ^{lse_s[LSE_ALU_COMPUTE], lse_s[LSE_MOV_ACC_TO_ALU], lse_s[LSE_MOV_LOW_TO_ALU]};

`ifdef CTRL_CHECK_EN
    logic ctrl_bad_s;
    logic ctrl_err_r;

    // Flag a destination whose strobe is missing, or an undefined read source
    always_comb begin
        ctrl_bad_s = 1'b0;
        if ((bus.data_bus_set[3:0] != SRC_BZ) && !write_strobe_hit(bus.data_bus_set[3:0], lse_s)) begin
            ctrl_bad_s = 1'b1;
        end else if (bus.data_bus_set[7:4] > SRC_BZ) begin
            ctrl_bad_s = 1'b1;
        end else begin
            ctrl_bad_s = 1'b0;
        end
    end

    // Sticky error flag cleared only by reset
    always_ff @(posedge fclk) begin
        if (!resb) begin
            ctrl_err_r <= 1'b0;
        end else begin
            ctrl_err_r <= ctrl_err_r | ctrl_bad_s;
        end
    end

    assign bus.ctrl_err = ctrl_err_r;
`else
    logic unused_ctrl_s;
    assign unused_ctrl_s = ^{bus.data_bus_set[3:0], lse_s[LSE_LOAD_ALU]};
`endif

endmodule
